div_unit: RTL and testbench



---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; ready 33 cycles after start, stall held meanwhile.
// DIV_ZERO_FASTPATH_EN: a zero divisor skips the iterations and completes one cycle after start.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               sgnq_q, sgnq_d;
  logic               sgnr_q, sgnr_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;
  logic               stall;

  always_comb begin
    a_mag   = (signed_i && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
    b_mag   = (signed_i && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;
    // rem < divisor before the shift, so the difference never reaches bit WIDTH unless it borrowed
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    ge      = ~rem_sub[WIDTH];
    rem_nx  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ge};
    rem_fix = sgnr_q ? ('0 - rem_nx) : rem_nx;
    quo_fix = sgnq_q ? ('0 - quo_nx) : quo_nx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    araw_d   = araw_q;
    sgnq_d   = sgnq_q;
    sgnr_d   = sgnr_q;
    div0_d   = div0_q;
    result_d = result_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i && !annul_i) begin
          stall  = 1'b1;
          rem_d  = '0;
          quo_d  = a_mag;
          dsr_d  = b_mag;
          araw_d = a_i;
          sgnq_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          sgnr_d = signed_i & a_i[WIDTH-1];
          div0_d = (b_i == '0);
`ifdef DIV_ZERO_FASTPATH_EN
          if (b_i == '0) begin
            state_d  = DONE;
            result_d = {a_i, {WIDTH{1'b1}}};
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = div0_q ? {araw_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
          end
        end
      end
      DONE: begin
        // start_i may still be high for the same instruction; never restart from here
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      araw_q   <= '0;
      sgnq_q   <= 1'b0;
      sgnr_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      araw_q   <= araw_d;
      sgnq_q   <= sgnq_d;
      sgnr_q   <= sgnr_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == DONE);
  assign stall_o  = resetn & stall;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, stall window, annul, reset and back-to-back issue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int tests = 0;
  int fails = 0;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = 33;
`endif

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .result_o (result_o),
    .ready_o  (ready_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide in the current cycle (T) and returns in the ready cycle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input bit hold);
    int lat;
    int stalls;
    signed_i = sgn;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    #1;
    check({tag, " stall@T"}, 64'(stall_o), 64'd1);
    stalls = 1;
    lat    = 0;
    while (!ready_o && lat < 40) begin
      step();
      lat++;
      if (!ready_o && stall_o) stalls++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
    check({tag, " stall@done"}, 64'(stall_o), 64'd0);
    check({tag, " result"}, result_o, exp_res);
    if (!hold) start_i = 1'b0;
  endtask

  initial begin
    int pulses;
    // reset state, with a start pending on the inputs
    start_i = 1'b1; signed_i = 1'b1; a_i = 32'd100; b_i = 32'd7;
    #2;
    check("rst result", result_o, 64'd0);
    check("rst ready", 64'(ready_o), 64'd0);
    check("rst stall", 64'(stall_o), 64'd0);
    start_i = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 33, 0);
    step();
    check("ready one pulse", 64'(ready_o), 64'd0);
    run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    step();
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33, 0);
    step();
    run_div("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33, 0);
    step();
    run_div("divu max/2^31", 1'b0, 32'hFFFFFFFF, 32'h80000000, {32'h7FFFFFFF, 32'h00000001}, 33, 0);
    step();
    run_div("divu x/0", 1'b0, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF}, LAT0, 0);
    step();
    run_div("div min/0", 1'b1, 32'h80000000, 32'd0, {32'h80000000, 32'hFFFFFFFF}, LAT0, 0);
    step();

    // annul at T+10: stall drops at once, no ready, result keeps the last value
    signed_i = 1'b1; a_i = 32'd50; b_i = 32'd3; start_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    check("annul stall same cycle", 64'(stall_o), 64'd0);
    step();
    annul_i = 1'b0;
    check("annul stall after", 64'(stall_o), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) pulses++;
      step();
    end
    check("annul ready pulses", 64'(pulses), 64'd0);
    check("annul result kept", result_o, {32'h80000000, 32'hFFFFFFFF});

    // reset at T+5 of a divide
    signed_i = 1'b0; a_i = 32'd9; b_i = 32'd2; start_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    resetn = 1'b0;
    #1;
    check("midrst result", result_o, 64'd0);
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst stall", 64'(stall_o), 64'd0);
    start_i = 1'b0;
    step();
    resetn = 1'b1;
    step();
    run_div("post-rst divu", 1'b0, 32'hFFFFFFFF, 32'd3, {32'h00000000, 32'h55555555}, 33, 0);
    step();

    // back-to-back with start held through DONE
    run_div("b2b first", 1'b0, 32'd1000, 32'd10, {32'h00000000, 32'h00000064}, 33, 1);
    signed_i = 1'b1; a_i = 32'hFFFFFF9C; b_i = 32'd7;
    step();
    check("b2b no double ready", 64'(ready_o), 64'd0);
    run_div("b2b second", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 0);
    step();
    check("b2b idle ready", 64'(ready_o), 64'd0);
    check("b2b idle stall", 64'(stall_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
